button_reader: RTL and testbench

- Read-side peripheral: the MCU-facing bus reads from the FPGA through it, as opposed to writing to it.
- Synchronises and debounces N_BTN active-high push-buttons.
- Latches press events into a sticky, clear-on-read event register.
- Returns either the debounced level or the pending events on an 8-bit read bus, selected by an enable strobe and a select bit.

---
 rtl/button_reader.sv | 95 +++++++++
 tb/tb_button_reader.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/button_reader.sv
// Debounced push-button reader with a sticky, clear-on-read press-event register.
// Optional registered event interrupt when BUTTON_READER_IRQ_EN is defined (irq tied low otherwise).
module button_reader #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    input  logic             rd_en,
    input  logic             rd_sel,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             en_sig,
    output logic             irq
);

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] sync_p0;
    logic [N_BTN-1:0] sync_p1;
    logic [N_BTN-1:0] stable;
    logic [N_BTN-1:0] evt;
    logic [15:0]      cnt [N_BTN];
    logic [N_BTN-1:0] done;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] evt_clr;
    logic [7:0]       rd_mux;

    assign en_sig = rd_en;

    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            done[i] = (sync_p1[i] != stable[i]) && (cnt[i] == CNT_LAST);
        end
        // A completing debounce with sync high can only be a 0->1 transition.
        rise    = done & sync_p1;
        evt_clr = (rd_en && rd_sel) ? evt : '0;
        rd_mux  = '0;
        rd_mux[N_BTN-1:0] = rd_sel ? evt : stable;
    end

    // Synchroniser and per-bit debounce counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            stable  <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync_p0 <= btn_in;
            sync_p1 <= sync_p0;
            for (int i = 0; i < N_BTN; i++) begin
                if (sync_p1[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (done[i]) begin
                    cnt[i]    <= '0;
                    stable[i] <= sync_p1[i];
                end else begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
        end
    end

    // Event register and read port; a new rise beats a coincident clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt      <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            evt      <= (evt & ~evt_clr) | rise;
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_mux;
            end
        end
    end

`ifdef BUTTON_READER_IRQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= |evt;
        end
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_button_reader.sv
// Scoreboard bench for button_reader: reads push expected data, a negedge monitor pops and compares.
module tb_button_reader;

    localparam int N_BTN = 4;
    localparam int DEB   = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_BTN-1:0] btn_in;
    logic             rd_en;
    logic             rd_sel;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             en_sig;
    logic             irq;

    logic [7:0] exp_q [$];
    int vectors     = 0;
    int miscompares = 0;

    button_reader #(
        .N_BTN          (N_BTN),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_in  (btn_in),
        .rd_en   (rd_en),
        .rd_sel  (rd_sel),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .en_sig  (en_sig),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge: one read sampled at the next posedge.
    task automatic issue(input logic sel, input logic [7:0] exp);
        rd_en  = 1'b1;
        rd_sel = sel;
        exp_q.push_back(exp);
        #1 check("en_sig", {7'd0, en_sig}, 8'h01);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rd_valid", 8'h01, 8'h00);
            end else begin
                check("rd_data", rd_data, exp_q.pop_front());
            end
        end
`ifndef BUTTON_READER_IRQ_EN
        check("irq_tied_low", {7'd0, irq}, 8'h00);
`endif
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        btn_in = '0;
        rd_en  = 1'b0;
        rd_sel = 1'b0;
        idle(3);
        check("reset_rd_data", rd_data, 8'h00);
        check("reset_rd_valid", {7'd0, rd_valid}, 8'h00);
        check("reset_irq", {7'd0, irq}, 8'h00);
        rst = 1'b0;
        idle(2);

        // Reset asserted mid-clock while a read is in flight
        btn_in = 4'hF;
        rd_en  = 1'b1;
        rd_sel = 1'b0;
        @(posedge clk);
        #1 check("pre_reset_rd_valid", {7'd0, rd_valid}, 8'h01);
        #1 rst = 1'b1;
        #1;
        check("async_rd_data", rd_data, 8'h00);
        check("async_rd_valid", {7'd0, rd_valid}, 8'h00);
        check("async_irq", {7'd0, irq}, 8'h00);
        @(negedge clk);
        rd_en = 1'b0;
        idle(1);
        rst = 1'b0;
        idle(1);
        issue(1'b0, 8'h00);
        btn_in = 4'h0;
        idle(15);

        // Clean press: stable rises on the 10th edge after the drive
        btn_in = 4'b0010;
        idle(9);
        issue(1'b0, 8'h00);
        issue(1'b0, 8'h02);
        issue(1'b1, 8'h02);
        btn_in = 4'b0000;
        idle(15);
        issue(1'b1, 8'h00);

        // Glitch shorter than the debounce window
        btn_in = 4'b0001;
        idle(5);
        btn_in = 4'b0000;
        idle(15);
        issue(1'b0, 8'h00);
        issue(1'b1, 8'h00);
        check("glitch_irq", {7'd0, irq}, 8'h00);

        // Bit2 debounce completes on the same edge as an event read
        btn_in = 4'b0001;
        idle(12);
        btn_in = 4'b0101;
        idle(9);
        issue(1'b1, 8'h01);
        issue(1'b1, 8'h04);
        issue(1'b1, 8'h00);
        btn_in = 4'b0000;
        idle(15);

        // Back-to-back reads
        btn_in = 4'b1001;
        idle(12);
        issue(1'b1, 8'h09);
        issue(1'b0, 8'h09);
        issue(1'b1, 8'h00);
        btn_in = 4'b0000;
        idle(15);

        // Interrupt timing around event bit3
        btn_in = 4'b1000;
        idle(9);
        @(negedge clk);
`ifdef BUTTON_READER_IRQ_EN
        check("irq_same_cycle_as_event", {7'd0, irq}, 8'h00);
        @(negedge clk);
        check("irq_rise", {7'd0, irq}, 8'h01);
        issue(1'b1, 8'h08);
        check("irq_hold_after_clear_edge", {7'd0, irq}, 8'h01);
        @(negedge clk);
        check("irq_fall", {7'd0, irq}, 8'h00);
`else
        check("irq_same_cycle_as_event", {7'd0, irq}, 8'h00);
        @(negedge clk);
        check("irq_rise", {7'd0, irq}, 8'h00);
        issue(1'b1, 8'h08);
        check("irq_hold_after_clear_edge", {7'd0, irq}, 8'h00);
        @(negedge clk);
        check("irq_fall", {7'd0, irq}, 8'h00);
`endif
        btn_in = 4'b0000;
        idle(15);
        issue(1'b0, 8'h00);
        idle(3);
        check("scoreboard_drained", 8'(exp_q.size()), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
